// File: rtl/forwarding_hazard_unit.sv
// forwarding_hazard_unit
//   Decode-stage register plus a DEPTH-deep chain of result tags. Detects
//   load-use hazards (one-cycle stall) and selects the nearest in-flight
//   producer of each source operand for forwarding.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low
//   ins/ins_valid  incoming instruction; ins_ready = ~stall
//   flush          kills the decode-stage instruction at the next edge
//   out_valid      decode-stage instruction issues this cycle
//   op_dec/imm/imm_sel, mem_en_ex/mem_rw_ex/mem_mux_sel_dm
//                  decode fields of the decode-stage instruction (0 when empty)
//   mux_sel_A/B    forward source: 0 = register file, k = tag stage k
//   RW_dm/wb_en    tag and valid of the last tag stage (writeback)
//   stall          load-use hazard this cycle
module forwarding_hazard_unit #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned RAW   = 5,
  parameter int unsigned SW    = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [31:0]    ins,
  input  logic           ins_valid,
  output logic           ins_ready,
  input  logic           flush,
  output logic           out_valid,
  output logic [5:0]     op_dec,
  output logic [15:0]    imm,
  output logic           imm_sel,
  output logic           mem_en_ex,
  output logic           mem_rw_ex,
  output logic           mem_mux_sel_dm,
  output logic [SW-1:0]  mux_sel_A,
  output logic [SW-1:0]  mux_sel_B,
  output logic [RAW-1:0] RW_dm,
  output logic           wb_en,
  output logic           stall
);

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_JMP,
    CLS_CJ,
    CLS_LD,
    CLS_ST,
    CLS_IMM
  } op_class_e;

  function automatic op_class_e classify(input logic [5:0] op);
    op_class_e c;
    casez (op)
      6'b011000: c = CLS_JMP;
      6'b0111??: c = CLS_CJ;
      6'b010100: c = CLS_LD;
      6'b010101: c = CLS_ST;
      6'b001???: c = CLS_IMM;
      default:   c = CLS_ALU;
    endcase
    return c;
  endfunction

  // Decode register
  logic        d_v_q, d_v_d;
  logic [31:0] d_ins_q, d_ins_d;

  // Tag chain; array index k-1 holds tag stage k
  logic           c_v_q   [DEPTH];
  logic           c_ld_q  [DEPTH];
  logic [RAW-1:0] c_tag_q [DEPTH];
  logic           c_v_d   [DEPTH];
  logic           c_ld_d  [DEPTH];
  logic [RAW-1:0] c_tag_d [DEPTH];

  op_class_e      d_cls;
  logic [5:0]     d_op;
  logic [RAW-1:0] d_dest;
  logic [RAW-1:0] d_src_a;
  logic [RAW-1:0] d_src_b;
  logic           writes_dest;
  logic           uses_a;
  logic           uses_b;

  always_comb begin
    d_op        = d_ins_q[31:26];
    d_dest      = d_ins_q[21 +: RAW];
    d_src_a     = d_ins_q[16 +: RAW];
    d_src_b     = d_ins_q[11 +: RAW];
    d_cls       = classify(d_op);
    writes_dest = (d_cls == CLS_ALU) || (d_cls == CLS_LD) || (d_cls == CLS_IMM);
    uses_a      = (d_cls != CLS_JMP);
    uses_b      = (d_cls == CLS_ALU) || (d_cls == CLS_ST) || (d_cls == CLS_CJ);
  end

  // Only a load sitting in stage 1 can cause a hazard; from stage 2 on its
  // data is forwardable.
  always_comb begin
    stall = d_v_q && c_v_q[0] && c_ld_q[0] &&
            ((uses_a && (d_src_a == c_tag_q[0])) ||
             (uses_b && (d_src_b == c_tag_q[0])));
    ins_ready = ~stall;
    out_valid = d_v_q & ~stall;
  end

  // Scan from the far end so the nearest matching stage overwrites the rest.
  always_comb begin
    mux_sel_A = '0;
    mux_sel_B = '0;
    for (int unsigned k = DEPTH; k >= 1; k--) begin
      if (d_v_q && uses_a && c_v_q[k-1] && (c_tag_q[k-1] == d_src_a))
        mux_sel_A = SW'(k);
      if (d_v_q && uses_b && c_v_q[k-1] && (c_tag_q[k-1] == d_src_b))
        mux_sel_B = SW'(k);
    end
  end

  always_comb begin
    op_dec         = d_v_q ? d_op : '0;
    imm            = d_v_q ? d_ins_q[15:0] : '0;
    imm_sel        = d_v_q && (d_cls == CLS_IMM);
    mem_en_ex      = d_v_q && ((d_cls == CLS_LD) || (d_cls == CLS_ST));
    mem_rw_ex      = d_v_q && (d_cls == CLS_ST);
    mem_mux_sel_dm = d_v_q && (d_cls == CLS_LD);
    RW_dm          = c_tag_q[DEPTH-1];
    wb_en          = c_v_q[DEPTH-1];
  end

  // Flush wins over both stall-hold and a fresh accept.
  always_comb begin
    d_v_d   = 1'b0;
    d_ins_d = d_ins_q;
    if (flush) begin
      d_v_d = 1'b0;
    end else if (ins_valid && ins_ready) begin
      d_v_d   = 1'b1;
      d_ins_d = ins;
    end else if (stall) begin
      d_v_d = d_v_q;
    end
  end

  // r0 is never entered as a valid producer; bubbles carry an all-zero entry.
  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      c_v_d[k]   = 1'b0;
      c_ld_d[k]  = 1'b0;
      c_tag_d[k] = '0;
    end
    if (out_valid && writes_dest && (d_dest != '0)) begin
      c_v_d[0]   = 1'b1;
      c_ld_d[0]  = (d_cls == CLS_LD);
      c_tag_d[0] = d_dest;
    end
    for (int unsigned k = 1; k < DEPTH; k++) begin
      c_v_d[k]   = c_v_q[k-1];
      c_ld_d[k]  = c_ld_q[k-1];
      c_tag_d[k] = c_tag_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_v_q   <= 1'b0;
      d_ins_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        c_v_q[k]   <= 1'b0;
        c_ld_q[k]  <= 1'b0;
        c_tag_q[k] <= '0;
      end
    end else begin
      d_v_q   <= d_v_d;
      d_ins_q <= d_ins_d;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        c_v_q[k]   <= c_v_d[k];
        c_ld_q[k]  <= c_ld_d[k];
        c_tag_q[k] <= c_tag_d[k];
      end
    end
  end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Testbench for forwarding_hazard_unit: a DEPTH=3 and a DEPTH=5 instance share
// one stimulus stream; a history-array reference model predicts every output.
module tb_forwarding_hazard_unit;

  localparam int D3  = 3;
  localparam int D5  = 5;
  localparam int SW3 = $clog2(D3 + 1);
  localparam int SW5 = $clog2(D5 + 1);

  localparam int K_ALU = 0;
  localparam int K_JMP = 1;
  localparam int K_CJ  = 2;
  localparam int K_LD  = 3;
  localparam int K_ST  = 4;
  localparam int K_IMM = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ins = '0;
  logic        ins_valid = 1'b0;
  logic        flush = 1'b0;

  logic           rdy3, ov3, isel3, men3, mrw3, mmux3, wb3, stall3;
  logic [5:0]     op3;
  logic [15:0]    imm3;
  logic [SW3-1:0] sa3, sb3;
  logic [4:0]     rw3;

  logic           rdy5, ov5, isel5, men5, mrw5, mmux5, wb5, stall5;
  logic [5:0]     op5;
  logic [15:0]    imm5;
  logic [SW5-1:0] sa5, sb5;
  logic [4:0]     rw5;

  forwarding_hazard_unit #(.DEPTH(D3), .RAW(5)) u3 (
    .clk(clk), .reset(reset), .ins(ins), .ins_valid(ins_valid), .ins_ready(rdy3),
    .flush(flush), .out_valid(ov3), .op_dec(op3), .imm(imm3), .imm_sel(isel3),
    .mem_en_ex(men3), .mem_rw_ex(mrw3), .mem_mux_sel_dm(mmux3),
    .mux_sel_A(sa3), .mux_sel_B(sb3), .RW_dm(rw3), .wb_en(wb3), .stall(stall3)
  );

  forwarding_hazard_unit #(.DEPTH(D5), .RAW(5)) u5 (
    .clk(clk), .reset(reset), .ins(ins), .ins_valid(ins_valid), .ins_ready(rdy5),
    .flush(flush), .out_valid(ov5), .op_dec(op5), .imm(imm5), .imm_sel(isel5),
    .mem_en_ex(men5), .mem_rw_ex(mrw5), .mem_mux_sel_dm(mmux5),
    .mux_sel_A(sa5), .mux_sel_B(sb5), .RW_dm(rw5), .wb_en(wb5), .stall(stall5)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: decode slot plus history of issued writers, hist[k] =
  // entry issued k cycles ago (index 1 = most recent).
  bit          m_dv;
  logic [31:0] m_ins;
  int          m_v   [0:8];
  int          m_ld  [0:8];
  int          m_tag [0:8];
  bit          e_stall;

  function automatic int op_kind(input int o);
    if (o == 24)              return K_JMP;
    if (o >= 28 && o <= 31)   return K_CJ;
    if (o == 20)              return K_LD;
    if (o == 21)              return K_ST;
    if (o >= 8 && o <= 15)    return K_IMM;
    return K_ALU;
  endfunction

  task automatic model_zero();
    m_dv  = 1'b0;
    m_ins = '0;
    for (int k = 0; k <= 8; k++) begin
      m_v[k] = 0; m_ld[k] = 0; m_tag[k] = 0;
    end
  endtask

  function automatic int nearest(input int src, input bit uses, input int depth);
    if (!m_dv || !uses) return 0;
    for (int k = 1; k <= depth; k++)
      if (m_v[k] != 0 && m_tag[k] == src) return k;
    return 0;
  endfunction

  task automatic compare_all();
    int kind, a, b, e_a3, e_b3, e_a5, e_b5;
    bit ua, ub, e_ov;
    logic [31:0] e_op, e_imm, e_isel, e_men, e_mrw, e_mmux;
    kind = op_kind(32'(m_ins[31:26]));
    a    = 32'(m_ins[20:16]);
    b    = 32'(m_ins[15:11]);
    ua   = (kind != K_JMP);
    ub   = (kind == K_ALU) || (kind == K_ST) || (kind == K_CJ);
    e_stall = m_dv && m_v[1] != 0 && m_ld[1] != 0 &&
              ((ua && a == m_tag[1]) || (ub && b == m_tag[1]));
    e_ov   = m_dv && !e_stall;
    e_op   = m_dv ? 32'(m_ins[31:26]) : 32'd0;
    e_imm  = m_dv ? 32'(m_ins[15:0]) : 32'd0;
    e_isel = 32'(m_dv && kind == K_IMM);
    e_men  = 32'(m_dv && (kind == K_LD || kind == K_ST));
    e_mrw  = 32'(m_dv && kind == K_ST);
    e_mmux = 32'(m_dv && kind == K_LD);
    e_a3 = nearest(a, ua, D3); e_b3 = nearest(b, ub, D3);
    e_a5 = nearest(a, ua, D5); e_b5 = nearest(b, ub, D5);

    check("rdy3",  32'(rdy3),  32'(!e_stall));
    check("stall3",32'(stall3),32'(e_stall));
    check("ov3",   32'(ov3),   32'(e_ov));
    check("op3",   32'(op3),   e_op);
    check("imm3",  32'(imm3),  e_imm);
    check("isel3", 32'(isel3), e_isel);
    check("men3",  32'(men3),  e_men);
    check("mrw3",  32'(mrw3),  e_mrw);
    check("mmux3", 32'(mmux3), e_mmux);
    check("selA3", 32'(sa3),   32'(e_a3));
    check("selB3", 32'(sb3),   32'(e_b3));
    check("rw3",   32'(rw3),   32'(m_tag[D3]));
    check("wb3",   32'(wb3),   32'(m_v[D3]));

    check("rdy5",  32'(rdy5),  32'(!e_stall));
    check("stall5",32'(stall5),32'(e_stall));
    check("ov5",   32'(ov5),   32'(e_ov));
    check("op5",   32'(op5),   e_op);
    check("imm5",  32'(imm5),  e_imm);
    check("isel5", 32'(isel5), e_isel);
    check("men5",  32'(men5),  e_men);
    check("mrw5",  32'(mrw5),  e_mrw);
    check("mmux5", 32'(mmux5), e_mmux);
    check("selA5", 32'(sa5),   32'(e_a5));
    check("selB5", 32'(sb5),   32'(e_b5));
    check("rw5",   32'(rw5),   32'(m_tag[D5]));
    check("wb5",   32'(wb5),   32'(m_v[D5]));
  endtask

  task automatic present(input logic [31:0] i, input logic v, input logic f);
    @(negedge clk);
    ins = i; ins_valid = v; flush = f;
    #1;
    compare_all();
  endtask

  task automatic advance();
    int kind, dest;
    bit ov, wr;
    logic [31:0] i;
    logic v, f;
    i = ins; v = ins_valid; f = flush;
    @(posedge clk);
    if (!reset) begin
      model_zero();
      return;
    end
    kind = op_kind(32'(m_ins[31:26]));
    dest = 32'(m_ins[25:21]);
    ov   = m_dv && !e_stall;
    wr   = (kind == K_ALU) || (kind == K_LD) || (kind == K_IMM);
    for (int k = 8; k >= 2; k--) begin
      m_v[k] = m_v[k-1]; m_ld[k] = m_ld[k-1]; m_tag[k] = m_tag[k-1];
    end
    if (ov && wr && dest != 0) begin
      m_v[1] = 1; m_ld[1] = (kind == K_LD) ? 1 : 0; m_tag[1] = dest;
    end else begin
      m_v[1] = 0; m_ld[1] = 0; m_tag[1] = 0;
    end
    if (f)                  m_dv = 1'b0;
    else if (v && !e_stall) begin m_dv = 1'b1; m_ins = i; end
    else if (!e_stall)      m_dv = 1'b0;
  endtask

  task automatic step(input logic [31:0] i, input logic v, input logic f);
    present(i, v, f);
    advance();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset in the middle of a cycle; checks outputs right away.
  task automatic rst_pulse();
    reset = 1'b0;
    ins_valid = 1'b0;
    flush = 1'b0;
    #1;
    model_zero();
    compare_all();
    check("rst_rdy", 32'(rdy3), 32'd1);
    check("rst_stall", 32'(stall3), 32'd0);
    check("rst_wb5", 32'(wb5), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input int d, input int a, input int b);
    return {op, 5'(d), 5'(a), 5'(b), 11'h5a5};
  endfunction

  localparam logic [5:0] OP_ALU = 6'b000000;
  localparam logic [5:0] OP_LD  = 6'b010100;

  logic [5:0] op_tab [10];
  int wb_cnt;

  initial begin
    op_tab = '{6'b000000, 6'b100011, 6'b010100, 6'b010100, 6'b010101,
               6'b001010, 6'b011000, 6'b011101, 6'b011110, 6'b111111};
    model_zero();
    e_stall = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    compare_all();
    check("init_rdy", 32'(rdy5), 32'd1);
    check("init_ov", 32'(ov3), 32'd0);
    reset = 1'b1;

    // Back-to-back ALU dependency forwards from stage 1
    step(mk(OP_ALU, 3, 1, 2), 1'b1, 1'b0);
    step(mk(OP_ALU, 4, 3, 3), 1'b1, 1'b0);
    present('0, 1'b0, 1'b0);
    check("b2b_selA", 32'(sa3), 32'd1);
    check("b2b_selB", 32'(sb3), 32'd1);
    check("b2b_stall", 32'(stall3), 32'd0);
    advance();
    idle(6);

    // Load-use: one stall, then forward from stage 2
    step(mk(OP_LD, 5, 1, 0), 1'b1, 1'b0);
    step(mk(OP_ALU, 6, 5, 2), 1'b1, 1'b0);
    present('0, 1'b0, 1'b0);
    check("lu_stall", 32'(stall3), 32'd1);
    check("lu_rdy", 32'(rdy3), 32'd0);
    advance();
    present('0, 1'b0, 1'b0);
    check("lu_selA", 32'(sa3), 32'd2);
    check("lu_ov", 32'(ov3), 32'd1);
    advance();
    idle(6);

    // Nearest producer wins; r0 never forwarded
    step(mk(OP_ALU, 7, 0, 0), 1'b1, 1'b0);
    step(mk(OP_ALU, 8, 0, 0), 1'b1, 1'b0);
    step(mk(OP_ALU, 7, 0, 0), 1'b1, 1'b0);
    step(mk(OP_ALU, 11, 7, 0), 1'b1, 1'b0);
    present('0, 1'b0, 1'b0);
    check("near_selA3", 32'(sa3), 32'd1);
    check("near_selA5", 32'(sa5), 32'd1);
    advance();
    step(mk(OP_ALU, 0, 1, 1), 1'b1, 1'b0);
    step(mk(OP_ALU, 12, 0, 0), 1'b1, 1'b0);
    present('0, 1'b0, 1'b0);
    check("r0_selA", 32'(sa3), 32'd0);
    advance();
    idle(8);

    // Load-use hazard killed by flush
    wb_cnt = 0;
    present(mk(OP_LD, 5, 0, 0), 1'b1, 1'b0); wb_cnt += 32'(wb3); advance();
    present(mk(OP_ALU, 6, 5, 0), 1'b1, 1'b0); wb_cnt += 32'(wb3); advance();
    present('0, 1'b0, 1'b1);
    check("fl_stall_before", 32'(stall3), 32'd1);
    wb_cnt += 32'(wb3);
    advance();
    present('0, 1'b0, 1'b0);
    check("fl_ov", 32'(ov3), 32'd0);
    check("fl_stall", 32'(stall3), 32'd0);
    wb_cnt += 32'(wb3);
    advance();
    for (int k = 0; k < 5; k++) begin
      present('0, 1'b0, 1'b0); wb_cnt += 32'(wb3); advance();
    end
    check("fl_wb_count", 32'(wb_cnt), 32'd1);

    // Reset pulsed mid-stall with the chain full
    step(mk(OP_ALU, 1, 0, 0), 1'b1, 1'b0);
    step(mk(OP_ALU, 2, 0, 0), 1'b1, 1'b0);
    step(mk(OP_LD, 3, 0, 0), 1'b1, 1'b0);
    step(mk(OP_ALU, 10, 3, 0), 1'b1, 1'b0);
    present('0, 1'b0, 1'b0);
    check("rs_stall_before", 32'(stall3), 32'd1);
    rst_pulse();
    wb_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      present('0, 1'b0, 1'b0); wb_cnt += 32'(wb3) + 32'(wb5); advance();
    end
    check("rs_no_wb", 32'(wb_cnt), 32'd0);

    // DEPTH=5 writeback latency
    for (int k = 1; k <= 6; k++) begin
      present(mk(OP_ALU, k, 0, 0), 1'b1, 1'b0);
      if (k == 6) check("d5_wb_early", 32'(wb5), 32'd0);
      advance();
    end
    present(mk(OP_ALU, 9, 1, 0), 1'b1, 1'b0);
    check("d5_rw", 32'(rw5), 32'd1);
    check("d5_wb", 32'(wb5), 32'd1);
    advance();
    present('0, 1'b0, 1'b0);
    check("d5_selA", 32'(sa5), 32'd0);
    advance();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        @(negedge clk);
        #2;
        rst_pulse();
      end else begin
        step({op_tab[$urandom_range(0, 9)], 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 11'($urandom)},
             1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 11) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/forwarding_hazard_unit.md
FORWARDING_HAZARD_UNIT -- requirements
Module: forwarding_hazard_unit

Interface
REQ-001 Parameter DEPTH, default 3, meaning number of result-tag stages tracked for forwarding (legal 1..7).
REQ-002 Parameter RAW, default 5, meaning register tag width (legal 3..5; tags taken from the low RAW bits of each 5-bit field).
REQ-003 Parameter SW, default $clog2(DEPTH+1), meaning width of each forward-select output.
REQ-004 clk  input  1  the only clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low; low clears all state immediately.
REQ-006 ins  input  32  instruction: op=ins[31:26], dest=ins[25:21], srcA=ins[20:16], srcB=ins[15:11], imm=ins[15:0].
REQ-007 ins_valid  input  1  ins carries a real instruction this cycle.
REQ-008 ins_ready  output  1  unit accepts ins this cycle; combinational, equal to ~stall.
REQ-009 flush  input  1  synchronous kill of the decode-stage instruction (taken branch/jump).
REQ-010 out_valid  output  1  decode-stage instruction issues this cycle (D_v & ~stall).
REQ-011 op_dec  output  6, imm  output  16, imm_sel  output  1  registered decode fields of the decode-stage instruction.
REQ-012 mem_en_ex, mem_rw_ex, mem_mux_sel_dm  output  1 each  memory enable, write(1)/read(0), load-data writeback select.
REQ-013 mux_sel_A, mux_sel_B  output  SW each  forward source: 0 = register file, k = result of tag stage k.
REQ-014 RW_dm  output  RAW, wb_en  output  1  tag and valid of tag stage DEPTH (writeback).
REQ-015 stall  output  1  load-use hazard detected this cycle.

Function
REQ-016 Opcode classes: JMP=011000, CJ=0111xx, LD=010100, ST=010101, IMM=001xxx; all others are register ALU ops.
REQ-017 Writes-dest: LD, IMM, ALU; no dest: JMP, CJ, ST. Uses srcA: all except JMP. Uses srcB: ALU, ST, CJ.
REQ-018 Decode register D (fields, D_v) loads ins on ins_valid & ins_ready; otherwise D_v clears unless stall holds D.
REQ-019 flush: D_v <= 0 at the edge; flush beats both stall and a new load; during flush, ins_ready stays ~stall, but an accepted ins is discarded.
REQ-020 Tag chain C[1..DEPTH], each {v, ld, tag}: C[k] <= C[k-1] every cycle; C[1] <= D entry if out_valid and writes-dest, else bubble (v=0).
REQ-021 Tag value 0 is never valid in the chain (r0 is not forwarded).
REQ-022 mux_sel_X = smallest k with C[k].v and C[k].tag == srcX and uses-srcX; 0 if none. Nearest stage wins.
REQ-023 stall = D_v & C[1].v & C[1].ld & ((usesA & srcA==C[1].tag) | (usesB & srcB==C[1].tag)); one bubble then forward from stage 2.
REQ-024 op_dec, imm, imm_sel (=IMM class), mem_en_ex (LD|ST), mem_rw_ex (ST), mem_mux_sel_dm (LD) reflect D when D_v, else all 0.
REQ-025 RW_dm/wb_en = C[DEPTH].tag/C[DEPTH].v; wb_en never asserts for a bubble.
REQ-026 Latency: ins accepted at edge n appears on decode outputs after n, enters C[1] at n+1, reaches RW_dm after n+DEPTH.
REQ-027 Fields wider than RAW: upper bits ignored for comparison.

Reset
REQ-028 reset low: D_v, all C[k].v, ld, tag cleared; all outputs 0 except ins_ready=1; effect asynchronous, mid-stall included.
REQ-029 Release of reset is synchronised by the integrator; first accept possible on the first edge with reset high.

Verification
REQ-030 ALU r3<-r1,r2 then ALU r4<-r3,r3 back-to-back (DEPTH=3) -> second gets mux_sel_A=1, mux_sel_B=1, no stall.
REQ-031 LD r5 then ALU r6<-r5,r2 -> stall=1, ins_ready=0 one cycle, then mux_sel_A=2, out_valid=1.
REQ-032 ALU r7 written by stages 1 and 3 both matching -> mux_sel_A=1; ALU writing r0 then reader of r0 -> mux_sel_A=0.
REQ-033 LD hazard with flush asserted same cycle -> D_v=0 next cycle, stall=0, no bubble duplicated, wb_en sequence shows LD only.
REQ-034 reset pulsed low mid-stall with chain full -> all outputs 0 immediately, ins_ready=1, no wb_en afterwards until new writes.
REQ-035 DEPTH=5 stream of 6 writers r1..r6 -> RW_dm = r1 exactly 5 cycles after r1 leaves D; reader of r1 after that sees mux_sel_A=0.
